// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter of the multicycle MIPS.
// Requester p0 is the CPU control path, p1 is the debug/loader port.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arbState_t;

    localparam int P0 = 0;
    localparam int P1 = 1;

    localparam int DATA_W_DEF    = 32;
    localparam int MEM_DEPTH_DEF = 256;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter.
// slave is the arbiter's view; master is the requesters plus the memory.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              p0_req;
    logic              p0_we;
    logic [DATA_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_ack;
    logic              p0_err;

    logic              p1_req;
    logic              p1_we;
    logic [DATA_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_ack;
    logic              p1_err;

    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] Adress;
    logic [DATA_W-1:0] WriteData;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] MemData;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  MemData,
        output p0_ack, p0_err, p1_ack, p1_err,
        output rdata, Adress, WriteData, MemRead, MemWrite
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output MemData,
        input  p0_ack, p0_err, p1_ack, p1_err,
        input  rdata, Adress, WriteData, MemRead, MemWrite
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; on a tie the
// requester that was not granted last time wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       lastGnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[P0] && req[P1]) begin
            if (lastGnt == 1'(P1)) gnt[P0] = 1'b1;
            else                   gnt[P1] = 1'b1;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises p0/p1 accesses onto the single-ported unified memory.
// Each access: latch in IDLE, one-cycle memory strobe in ACCESS, ack in RESP.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  IDLE   | waiting; on any request pick a winner and latch its access
//  ACCESS | MemRead/MemWrite strobed for one cycle, read data captured
//  RESP   | ack (and err) pulsed to the latched winner, then back to IDLE
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
)(
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    arbState_t state;
    arbState_t nextState;

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              lastGnt;

    logic              winPort;
    logic              winWe;
    logic              winErr;
    logic [DATA_W-1:0] winAddr;
    logic [DATA_W-1:0] winWdata;

    logic              latPort;
    logic              latWe;
    logic              latErr;
    logic [DATA_W-1:0] addrReg;
    logic [DATA_W-1:0] wdataReg;
    logic [DATA_W-1:0] rdataReg;

    logic              memRead;
    logic              memWrite;
    logic              p0Ack;
    logic              p1Ack;
    logic              p0Err;
    logic              p1Err;

    assign req = {bus.p1_req, bus.p0_req};

    rr_arb2 uArb (
        .req     (req),
        .lastGnt (lastGnt),
        .gnt     (gnt)
    );

    // Winner mux; the full address width is range-checked so high bits cannot alias.
    always_comb begin
        winPort  = gnt[P1];
        winWe    = winPort ? bus.p1_we    : bus.p0_we;
        winAddr  = winPort ? bus.p1_addr  : bus.p0_addr;
        winWdata = winPort ? bus.p1_wdata : bus.p0_wdata;
        winErr   = (winAddr >= DATA_W'(MEM_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        p0Ack     = 1'b0;
        p1Ack     = 1'b0;
        p0Err     = 1'b0;
        p1Err     = 1'b0;
        case (state)
            IDLE: begin
                if (|req) nextState = winErr ? RESP : ACCESS;
            end
            ACCESS: begin
                memRead   = ~latWe;
                memWrite  = latWe;
                nextState = RESP;
            end
            RESP: begin
                // Always return to IDLE: the winner's req is still high this cycle.
                if (latPort == 1'(P1)) begin
                    p1Ack = 1'b1;
                    p1Err = latErr;
                end else begin
                    p0Ack = 1'b1;
                    p0Err = latErr;
                end
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Adress/WriteData only load for accesses that reach ACCESS, so they hold
    // their previous value across out-of-range requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGnt  <= 1'(P1);
            latPort  <= 1'b0;
            latWe    <= 1'b0;
            latErr   <= 1'b0;
            addrReg  <= '0;
            wdataReg <= '0;
            rdataReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        latPort <= winPort;
                        latWe   <= winWe;
                        latErr  <= winErr;
                        lastGnt <= winPort;
                        if (winErr) begin
                            rdataReg <= '0;
                        end else begin
                            addrReg  <= winAddr;
                            wdataReg <= winWdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!latWe) rdataReg <= bus.MemData;
                end
                default: ;
            endcase
        end
    end

    assign bus.Adress    = addrReg;
    assign bus.WriteData = wdataReg;
    assign bus.rdata     = rdataReg;
    assign bus.MemRead   = memRead;
    assign bus.MemWrite  = memWrite;
    assign bus.p0_ack    = p0Ack;
    assign bus.p1_ack    = p1Ack;
    assign bus.p0_err    = p0Err;
    assign bus.p1_err    = p1Err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: plays both requesters and a 256-word memory.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DATA_W(DW)) bus ();

    mem_arbiter #(.DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] mem [0:255];
    assign bus.MemData = mem[bus.Adress[7:0]];
    always @(posedge clk) if (bus.MemWrite) mem[bus.Adress[7:0]] <= bus.WriteData;

    int nCompared = 0;
    int nMismatched = 0;
    int p0AckCnt = 0, p1AckCnt = 0, rdPulses = 0, wrPulses = 0;

    // Per-cycle protocol monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.MemRead)  rdPulses++;
            if (bus.MemWrite) wrPulses++;
            if (bus.p0_ack)   p0AckCnt++;
            if (bus.p1_ack)   p1AckCnt++;
            nCompared++;
            if ((bus.MemRead & bus.MemWrite) !== 1'b0) begin
                nMismatched++;
                $display("FAIL mem_excl t=%0t: MemRead=%b MemWrite=%b, required not both 1", $time, bus.MemRead, bus.MemWrite);
            end
            nCompared++;
            if ((bus.p0_ack & bus.p1_ack) !== 1'b0) begin
                nMismatched++;
                $display("FAIL one_ack t=%0t: p0_ack=%b p1_ack=%b, required at most one", $time, bus.p0_ack, bus.p1_ack);
            end
            nCompared++;
            if (((bus.p0_ack & ~bus.p0_req) | (bus.p1_ack & ~bus.p1_req)) !== 1'b0) begin
                nMismatched++;
                $display("FAIL ack_match t=%0t: ack without pending req (p0 %b/%b p1 %b/%b)", $time, bus.p0_ack, bus.p0_req, bus.p1_ack, bus.p1_req);
            end
        end
    end

    // Issue one request at cycle start; returns ack latency in cycles (-1 on timeout).
    task automatic runReq(input bit port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic err,
                          output logic [31:0] rd);
        lat = -1;
        err = 1'bx;
        rd  = 'x;
        if (port == 1'b0) begin
            bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wd; bus.p0_req = 1'b1;
        end else begin
            bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wd; bus.p1_req = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if ((port == 1'b0 && bus.p0_ack) || (port == 1'b1 && bus.p1_ack)) begin
                lat = k;
                err = port ? bus.p1_err : bus.p0_err;
                rd  = bus.rdata;
                break;
            end
        end
        @(posedge clk); #1;
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
    endtask

    task automatic test_reset();
        int ackSnap;
        bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = 0; bus.p0_wdata = 0;
        bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = 0; bus.p1_wdata = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        @(negedge clk);
        nCompared++;
        if ({bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err, bus.MemRead, bus.MemWrite} !== 6'b0) begin
            nMismatched++;
            $display("FAIL reset_ctrl: ack/err/rd/wr=%b required 000000",
                     {bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err, bus.MemRead, bus.MemWrite});
        end
        nCompared++;
        if ({bus.Adress, bus.WriteData, bus.rdata} !== 96'h0) begin
            nMismatched++;
            $display("FAIL reset_data: Adress=%h WriteData=%h rdata=%h required all 0", bus.Adress, bus.WriteData, bus.rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem[8'h20] = 32'h11111111;
        @(posedge clk); #1;
        ackSnap = p0AckCnt;
        bus.p0_we = 1'b1; bus.p0_addr = 32'h20; bus.p0_wdata = 32'hCAFEF00D; bus.p0_req = 1'b1;
        @(posedge clk); #3;
        nCompared++;
        if (bus.MemWrite !== 1'b1) begin
            nMismatched++;
            $display("FAIL abort_pre: MemWrite=%b required 1 in ACCESS", bus.MemWrite);
        end
        rst_n = 1'b0;
        #1;
        nCompared++;
        if (bus.MemWrite !== 1'b0) begin
            nMismatched++;
            $display("FAIL abort_drop: MemWrite=%b required 0 right after reset", bus.MemWrite);
        end
        bus.p0_req = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nCompared++;
        if (p0AckCnt !== ackSnap) begin
            nMismatched++;
            $display("FAIL abort_ack: p0 acks=%0d required %0d", p0AckCnt, ackSnap);
        end
        nCompared++;
        if (mem[8'h20] !== 32'h11111111) begin
            nMismatched++;
            $display("FAIL abort_mem: mem[0x20]=%h required 11111111", mem[8'h20]);
        end
    endtask

    task automatic test_write_read();
        int lat, rdS, wrS;
        logic err;
        logic [31:0] rd;
        rdS = rdPulses; wrS = wrPulses;
        runReq(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, err, rd);
        nCompared++;
        if (lat !== 2 || err !== 1'b0 || rd !== 32'h0) begin
            nMismatched++;
            $display("FAIL wr_ack: lat=%0d err=%b rdata=%h required 2 0 00000000", lat, err, rd);
        end
        nCompared++;
        if (wrPulses - wrS !== 1 || rdPulses - rdS !== 0 || mem[8'h10] !== 32'hDEADBEEF) begin
            nMismatched++;
            $display("FAIL wr_mem: wr=%0d rd=%0d mem=%h required 1 0 deadbeef", wrPulses - wrS, rdPulses - rdS, mem[8'h10]);
        end
        nCompared++;
        if (bus.Adress !== 32'h10 || bus.WriteData !== 32'hDEADBEEF) begin
            nMismatched++;
            $display("FAIL wr_hold: Adress=%h WriteData=%h required 00000010 deadbeef", bus.Adress, bus.WriteData);
        end
        rdS = rdPulses; wrS = wrPulses;
        runReq(1'b0, 1'b0, 32'h10, 32'h0, lat, err, rd);
        nCompared++;
        if (lat !== 2 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
            nMismatched++;
            $display("FAIL rd_ack: lat=%0d err=%b rdata=%h required 2 0 deadbeef", lat, err, rd);
        end
        nCompared++;
        if (rdPulses - rdS !== 1 || wrPulses - wrS !== 0) begin
            nMismatched++;
            $display("FAIL rd_pulse: rd=%0d wr=%0d required 1 0", rdPulses - rdS, wrPulses - wrS);
        end
        runReq(1'b1, 1'b1, 32'h11, 32'h12345678, lat, err, rd);
        nCompared++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || mem[8'h11] !== 32'h12345678) begin
            nMismatched++;
            $display("FAIL p1_wr: lat=%0d rdata=%h mem=%h required 2 deadbeef 12345678", lat, rd, mem[8'h11]);
        end
    endtask

    task automatic test_round_robin();
        int ackPort[8], ackCyc[8], nAck;
        logic [31:0] ackData[8];
        nAck = 0;
        for (int i = 0; i < 8; i++) begin ackPort[i] = -1; ackCyc[i] = -1; ackData[i] = 'x; end
        @(negedge clk);
        rst_n = 1'b0;
        mem[1] = 32'hA1; mem[2] = 32'hB2;
        bus.p0_we = 1'b0; bus.p0_addr = 32'h1; bus.p0_req = 1'b1;
        bus.p1_we = 1'b0; bus.p1_addr = 32'h2; bus.p1_req = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (nAck < 8 && bus.p0_ack) begin ackPort[nAck] = 0; ackCyc[nAck] = c; ackData[nAck] = bus.rdata; nAck++; end
            if (nAck < 8 && bus.p1_ack) begin ackPort[nAck] = 1; ackCyc[nAck] = c; ackData[nAck] = bus.rdata; nAck++; end
            @(posedge clk); #1;
        end
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        nCompared++;
        if (nAck !== 4) begin
            nMismatched++;
            $display("FAIL rr_count: acks=%0d required 4", nAck);
        end
        for (int i = 0; i < 4; i++) begin
            nCompared++;
            if (ackPort[i] !== i % 2 || ackCyc[i] !== 2 + 3 * i ||
                ackData[i] !== ((i % 2) ? 32'hB2 : 32'hA1)) begin
                nMismatched++;
                $display("FAIL rr_ack%0d: port=%0d cycle=%0d rdata=%h required %0d %0d %h",
                         i, ackPort[i], ackCyc[i], ackData[i], i % 2, 2 + 3 * i, (i % 2) ? 32'hB2 : 32'hA1);
            end
        end
    endtask

    task automatic test_out_of_range();
        int lat, rdS, wrS;
        logic err;
        logic [31:0] rd;
        rdS = rdPulses; wrS = wrPulses;
        runReq(1'b1, 1'b0, 32'h100, 32'h0, lat, err, rd);
        nCompared++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
            nMismatched++;
            $display("FAIL oor_ack: lat=%0d err=%b rdata=%h required 1 1 00000000", lat, err, rd);
        end
        nCompared++;
        if (rdPulses - rdS !== 0 || wrPulses - wrS !== 0 || bus.Adress !== 32'h2) begin
            nMismatched++;
            $display("FAIL oor_mem: rd=%0d wr=%0d Adress=%h required 0 0 00000002", rdPulses - rdS, wrPulses - wrS, bus.Adress);
        end
        mem[255] = 32'h55AA55AA;
        runReq(1'b1, 1'b0, 32'hFF, 32'h0, lat, err, rd);
        nCompared++;
        if (lat !== 2 || err !== 1'b0 || rd !== 32'h55AA55AA) begin
            nMismatched++;
            $display("FAIL top_word: lat=%0d err=%b rdata=%h required 2 0 55aa55aa", lat, err, rd);
        end
        wrS = wrPulses;
        runReq(1'b0, 1'b1, 32'h80000010, 32'h00000BAD, lat, err, rd);
        nCompared++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || wrPulses - wrS !== 0 || mem[8'h10] !== 32'hDEADBEEF) begin
            nMismatched++;
            $display("FAIL wide_addr: lat=%0d err=%b rdata=%h wr=%0d mem=%h required 1 1 00000000 0 deadbeef",
                     lat, err, rd, wrPulses - wrS, mem[8'h10]);
        end
    endtask

    task automatic test_back_to_back();
        int ackPort[8], ackCyc[8], nAck;
        logic [31:0] ackData[8];
        int expPort[5], expCyc[5];
        expPort = '{1, 1, 1, 0, 1};
        expCyc  = '{2, 5, 8, 11, 14};
        nAck = 0;
        for (int i = 0; i < 8; i++) begin ackPort[i] = -1; ackCyc[i] = -1; ackData[i] = 'x; end
        mem[3] = 32'h33; mem[4] = 32'h44;
        bus.p0_we = 1'b0; bus.p0_addr = 32'h4; bus.p0_req = 1'b0;
        bus.p1_we = 1'b0; bus.p1_addr = 32'h3; bus.p1_req = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c == 7)  bus.p0_req = 1'b1;
            if (c == 12) bus.p0_req = 1'b0;
            @(negedge clk);
            if (nAck < 8 && bus.p0_ack) begin ackPort[nAck] = 0; ackCyc[nAck] = c; ackData[nAck] = bus.rdata; nAck++; end
            if (nAck < 8 && bus.p1_ack) begin ackPort[nAck] = 1; ackCyc[nAck] = c; ackData[nAck] = bus.rdata; nAck++; end
            @(posedge clk); #1;
        end
        bus.p1_req = 1'b0;
        nCompared++;
        if (nAck !== 5) begin
            nMismatched++;
            $display("FAIL b2b_count: acks=%0d required 5", nAck);
        end
        for (int i = 0; i < 5; i++) begin
            nCompared++;
            if (ackPort[i] !== expPort[i] || ackCyc[i] !== expCyc[i] ||
                ackData[i] !== (expPort[i] == 1 ? 32'h33 : 32'h44)) begin
                nMismatched++;
                $display("FAIL b2b_ack%0d: port=%0d cycle=%0d rdata=%h required %0d %0d %h",
                         i, ackPort[i], ackCyc[i], ackData[i], expPort[i], expCyc[i],
                         expPort[i] == 1 ? 32'h33 : 32'h44);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_out_of_range();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
